// File: rtl/mac_sequencer.sv
// Dot-product sequencer: streams N buffered signed operand pairs through an external
// start/done multiplier and accumulates the products, with optional ReLU on the result.
module mac_sequencer #(
  parameter int N     = 9,
  parameter int ACC_W = 22
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [3:0]              wr_addr,
  input  logic signed [8:0]       wr_a,
  input  logic signed [8:0]       wr_b,
  input  logic                    start,
  input  logic                    relu_en,
  output logic                    busy,
  output logic                    done,
  output logic signed [ACC_W-1:0] result,
  output logic signed [8:0]       mul_a,
  output logic signed [8:0]       mul_b,
  output logic                    mul_start,
  input  logic                    mul_done,
  input  logic signed [17:0]      mul_result
);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN, OUT} state_e;

  state_e                   state_q, state_d;
  logic [3:0]               idx_q, idx_d;
  logic [3:0]               idx_nxt;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  result_q, result_d;
  logic                     relu_q, relu_d;
  logic signed [8:0]        mul_a_q, mul_a_d;
  logic signed [8:0]        mul_b_q, mul_b_d;
  logic                     mul_start_q, mul_start_d;
  logic signed [8:0]        buf_a_q [N];
  logic signed [8:0]        buf_a_d [N];
  logic signed [8:0]        buf_b_q [N];
  logic signed [8:0]        buf_b_d [N];

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    result_d    = result_q;
    relu_d      = relu_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    mul_start_d = mul_start_q;
    buf_a_d     = buf_a_q;
    buf_b_d     = buf_b_q;
    idx_nxt     = idx_q + 4'd1;

    case (state_q)
      IDLE: begin
        if (wr_en && (32'(wr_addr) < 32'(N))) begin
          buf_a_d[wr_addr] = wr_a;
          buf_b_d[wr_addr] = wr_b;
        end
        // A same-cycle write and start launches with the pre-write entry 0.
        if (start) begin
          idx_d       = '0;
          acc_d       = '0;
          mul_a_d     = buf_a_q[0];
          mul_b_d     = buf_b_q[0];
          mul_start_d = 1'b1;
          relu_d      = relu_en;
          state_d     = REQ;
        end
      end
      REQ: begin
        if (mul_done) begin
          acc_d       = acc_q + ACC_W'(mul_result);
          mul_start_d = 1'b0;
          state_d     = DRAIN;
        end
      end
      DRAIN: begin
        // Wait out the multiplier's lingering done before issuing the next pair.
        if (!mul_done) begin
          if (idx_q == 4'(N - 1)) begin
            result_d = (relu_q && (acc_q < 0)) ? '0 : acc_q;
            state_d  = OUT;
          end else begin
            idx_d       = idx_nxt;
            mul_a_d     = buf_a_q[idx_nxt];
            mul_b_d     = buf_b_q[idx_nxt];
            mul_start_d = 1'b1;
            state_d     = REQ;
          end
        end
      end
      OUT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      relu_q      <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_start_q <= 1'b0;
      buf_a_q     <= '{default: '0};
      buf_b_q     <= '{default: '0};
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      relu_q      <= relu_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      mul_start_q <= mul_start_d;
      buf_a_q     <= buf_a_d;
      buf_b_q     <= buf_b_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == OUT);
  assign result    = result_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign mul_start = mul_start_q;

endmodule

// File: doc/mac_sequencer.md
# mac_sequencer

Initiator-side controller for the CNN datapath's start/done multiplier interface. It holds N pairs of signed 9-bit operands and feeds them one pair at a time to an external 9x9 signed multiplier over the `mul_start`/`mul_done` handshake. It accumulates the 18-bit products into a full-precision sum and presents one dot-product result (for example, one 3x3 convolution tap set) with an optional ReLU.

## Interface
- `N`, default 9: number of operand pairs per dot product, range 2..16.
- `ACC_W`, default 22: accumulator and result width in bits, signed.
- `clk`  in  1  single clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  write one operand pair into the buffer.
- `wr_addr`  in  4  buffer index, 0..N-1. Writes to indices ≥N are ignored.
- `wr_a`, `wr_b`  in  9 each  signed operands.
- `start`  in  1  begin a dot product. Sampled only in IDLE.
- `relu_en`  in  1  sampled together with `start`. When set, a negative result is clamped to 0.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`, inclusive.
- `done`  out  1  one-cycle pulse; `result` is valid in that cycle.
- `result`  out  ACC_W  signed. Holds its value until the next accepted `start` or reset.
- `mul_a`, `mul_b`  out  9 each  signed operands to the multiplier. Registered.
- `mul_start`  out  1  multiplier request. Registered.
- `mul_done`  in  1  multiplier completion flag.
- `mul_result`  in  18  signed product.

## Operation
- Operand buffer: N × (9+9) bits.
  - A write takes effect on the clock edge, only while in IDLE. Writes in any other state are dropped.
  - The buffer keeps its contents across dot products.
- FSM states are IDLE, REQ, DRAIN and OUT.
  - IDLE:
    - `start`=1 → idx←0, acc←0, `mul_a`/`mul_b` ← buffer[0], `mul_start`←1, latch `relu_en`, go to REQ.
  - REQ:
    - Hold `mul_start`=1 with stable operands until `mul_done`=1 is sampled.
    - Then acc ← acc + sign-extended `mul_result`, `mul_start`←0, go to DRAIN.
  - DRAIN:
    - Wait until `mul_done`=0 is sampled. This discards the multiplier's stale done.
    - Then, if idx=N-1, go to OUT.
    - Otherwise idx←idx+1, load buffer[idx+1] onto `mul_a`/`mul_b`, `mul_start`←1, go to REQ.
  - OUT (entered on the edge that leaves the final DRAIN):
    - `result` ← (relu && acc<0) ? 0 : acc, `done`←1.
    - Next state is IDLE, with `done` returning to 0.
- Arithmetic:
  - Accumulation is two's complement in ACC_W bits.
  - ACC_W=22 is exact for N≤16 (worst case 16·65536 = 2^20).
  - A smaller ACC_W wraps modulo 2^ACC_W; there is no saturation.
- `start` while `busy` is ignored and causes no queueing.
- The multiplier may take any latency ≥1 cycle. There is no timeout.
- `mul_done` arriving while in IDLE or OUT is ignored.

## Timing
- All outputs are 0 during and after reset: `busy`, `done`, `result`, `mul_a`, `mul_b`, `mul_start`. State goes to IDLE and the buffer is cleared to 0.
- An asynchronous reset asserted mid-sequence aborts immediately. `mul_start` drops without waiting for `mul_done`.
- With a 1-cycle-latency multiplier (done registered on start, cleared when start is low), each pair costs 4 cycles: REQ 2, DRAIN 2.
- Latency for a 1-cycle multiplier: `start` sampled at edge s → `done` high in the cycle after edge s+4N. With N=9 that is 36 cycles.
- `busy` goes high after edge s and falls together with `done` deasserting.
- Back-to-back operation: the earliest next `start` is sampled in the cycle following the `done` pulse.

## Test plan
- Load a=1..9 and b=2 for every pair; start with `relu_en`=0 → `done` 36 cycles after start, `result`=90, `mul_start` toggles 9 times.
- All a=-256 and b=-256 → `result`=589824. All a=-256 and b=255 → `result`=-587520; the same case with `relu_en`=1 → `result`=0.
- While `busy`: pulse `start`, then write wr_addr=0 with a=100 → no restart, `result` unchanged. A following run shows the old buffer[0] was used.
- Multiplier model with 3-cycle latency → `mul_start` held until `mul_done` and the same sums as above. With N=9, `done` comes 9 extra-latency intervals later than the baseline.
- Assert reset after the 4th product → all outputs 0 on the same edge, no `done`. A new start without reloading the buffer → `result`=0.
- Write wr_addr=12 (≥N) → buffer unchanged. A partial reload of index 8 only (a=5, b=-3) after the first test → `result`=90-18-15 = 57.
